regfile_multiport: RTL
======================

Name: regfile_multiport

Overview:
- Parametrised successor to the 2-read/1-write 64-bit register file.
- Configurable data width, depth and read-port count, with a configurable hardwired-zero index.
- Adds a synchronous-reset, one-entry-per-cycle clear sequencer with a Busy flag.
- Sits in the decode stage and feeds operand buses to the ALU and data-memory paths.

Parameters:
- WIDTH, 64: data width of every entry and bus.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of independent asynchronous read ports.
- ZERO_IDX, 31: index that always reads 0 and ignores writes; a value >= DEPTH disables the zero register.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high; starts the clear sequence.
- RA  input  NUM_RD*ADDR_W  flattened read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- BusR  output  NUM_RD*WIDTH  flattened read data; port k uses bits [k*WIDTH +: WIDTH].
- RW  input  ADDR_W  write address.
- BusW  input  WIDTH  write data.
- RegWr  input  1  write enable.
- Busy  output  1  high while the clear sequence is running.

Behaviour:
- Storage: DEPTH x WIDTH array. State machine has two states, IDLE and CLEAR, plus a clear pointer ptr[ADDR_W-1:0].
- Rising edge with Reset=1:
  - state <= CLEAR, ptr <= 0, mem[0] <= 0.
  - Applies regardless of current state; a reset mid-clear restarts from entry 0.
- Rising edge in CLEAR with Reset=0:
  - mem[ptr] <= 0.
  - If ptr == DEPTH-1, state <= IDLE; otherwise ptr <= ptr+1.
  - After Reset falls, exactly DEPTH rising edges clear entries 0..DEPTH-1. Busy is low after the DEPTH-th edge.
- Busy = (state == CLEAR). It is combinational from state, so it is 1 during and after reset.
- Writes while Busy: RegWr is ignored and the array is touched only by the clearer.
- Rising edge in IDLE with RegWr=1 and RW != ZERO_IDX: mem[RW] <= BusW. A write to ZERO_IDX is discarded.
- Reads are combinational, with zero clock latency. For each port k:
  - If Busy: BusR_k = 0.
  - Else if RA_k == ZERO_IDX: BusR_k = 0.
  - Else: BusR_k = mem[RA_k], subject to the optional bypass below.
- Multiple ports reading the same address all return the same value. There is no port priority and no conflict.
- Write data wider than WIDTH does not exist; all buses are exactly WIDTH. Addresses wrap naturally within ADDR_W bits, so there are no out-of-range indices.
- Reset value of outputs: Busy=1. BusR = 0 on every port until the clear completes.
- No delays (#) in the RTL; timing is purely cycle-based.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - Condition: state IDLE, RegWr=1, RW != ZERO_IDX and RA_k == RW.
  - Result: BusR_k = BusW in the same cycle, before the edge commits it. The new value is visible without waiting.
- Undefined: BusR_k returns the old stored value until the write edge; the new value appears after that edge.
- Zero-register and Busy masking take precedence over the bypass in both builds.

Test Plan:
- Reset and clear:
  - Stimulus: assert Reset 2 cycles, deassert, count edges.
  - Required: Busy=1 for exactly 32 edges after deassert, then 0; all 32 entries read 0 on both ports.
- Basic write/read:
  - Stimulus: after clear, write 64'hDEAD_BEEF_0123_4567 to R5; then RA0=5, RA1=5.
  - Required: both ports show 64'hDEAD_BEEF_0123_4567 on the following cycle.
- Zero register:
  - Stimulus: write 64'hFFFF_FFFF_FFFF_FFFF to R31; read R31.
  - Required: BusR=0; the R30 value is unchanged.
- Bypass:
  - Stimulus: same-cycle RegWr=1, RW=7, BusW=64'h1234 with RA0=7, R7 previously 64'h0.
  - Required: BusR0=64'h1234 with REGFILE_BYPASS_EN defined; BusR0=64'h0 without it, then 64'h1234 after the edge.
- Reset mid-clear:
  - Stimulus: re-assert Reset 10 edges into the clear, with R20 written 64'hAA before the first reset.
  - Required: ptr restarts; Busy stays high 32 more edges after the second deassert; R20 reads 0.
- Write during Busy, plus parametrisation:
  - Stimulus: RegWr=1, RW=3, BusW=64'h55 while Busy; rerun the whole set with WIDTH=32, ADDR_W=3, NUM_RD=3, ZERO_IDX=7.
  - Required: R3 reads 0 after the clear; Busy lasts 8 edges; all 3 ports are independent.

Source files
------------

// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with a hardwired-zero index and a
// one-entry-per-cycle clear sequencer. Optional write-to-read forwarding: REGFILE_BYPASS_EN.
module regfile_multiport #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_IDX = 31
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*WIDTH-1:0]  BusR,
    input  logic [ADDR_W-1:0]        RW,
    input  logic [WIDTH-1:0]         BusW,
    input  logic                     RegWr,
    output logic                     Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    // An out-of-range ZERO_IDX turns the zero register off entirely.
    localparam bit ZERO_EN = (ZERO_IDX >= 0) && (ZERO_IDX < DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wrZero;
    logic              wrEn;

    assign Busy = (state == CLEAR);

    always_comb begin
        wrZero = ZERO_EN && (RW == ZERO_ADDR);
        wrEn   = (state == IDLE) && RegWr && !wrZero;
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        if (Reset) begin
            stateNext = CLEAR;
            ptrNext   = '0;
        end else if (state == CLEAR) begin
            if (ptr == LAST_ADDR) begin
                stateNext = IDLE;
            end else begin
                ptrNext = ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        state <= stateNext;
        ptr   <= ptrNext;
    end

    // While clearing, only the sequencer touches the array.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem[0] <= '0;
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wrEn) begin
            mem[RW] <= BusW;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;

        assign addr = RA[k*ADDR_W +: ADDR_W];

        // Busy and zero-register masking override the forwarded value.
        always_comb begin
            data = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (wrEn && (RW == addr)) begin
                data = BusW;
            end
`endif
            if (Busy || (ZERO_EN && (addr == ZERO_ADDR))) begin
                data = '0;
            end
        end

        assign BusR[k*WIDTH +: WIDTH] = data;
    end

endmodule
